voice_allocator: RTL

- Producer of the time-multiplexed note stream that the pipelined phase bank consumes.
- Accepts note-on and note-off events over a valid/ready handshake and keeps a table of NBANKS voices.
- On every clk_en it emits one voice's MIDI note per slot, round-robin, with note 7'h00 meaning silent.
- Sits between the MIDI front-end and the phase bank; its o_midi drives the phase bank's i_midi directly.

---
 rtl/synth_pkg.sv | 6 +
 rtl/voice_allocator_table.sv | 35 +++
 rtl/voice_allocator.sv | 104 ++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared constants and FSM encoding for the voice allocator and the phase bank
package synth_pkg;
  localparam int NBANKS = 10;
  localparam logic [6:0] NOTE_SILENT = 7'h00;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
endpackage

// File: rtl/voice_allocator_table.sv
// voice_table: NBANKS x 7 note store with two read ports, one write port and clear-by-match
module voice_table import synth_pkg::*; #(
  parameter int NBANKS = synth_pkg::NBANKS,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLOT_W-1:0] rd_a_idx,
  output logic [6:0]        rd_a,
  input  logic [SLOT_W-1:0] rd_b_idx,
  output logic [6:0]        rd_b,
  input  logic              we,
  input  logic [SLOT_W-1:0] wr_idx,
  input  logic [6:0]        wr_note,
  input  logic              clr,
  input  logic [6:0]        clr_note,
  output logic [NBANKS-1:0] busy
);
  logic [6:0] tbl_q [NBANKS];
  assign rd_a = tbl_q[rd_a_idx];
  assign rd_b = tbl_q[rd_b_idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANKS; i++) tbl_q[i] <= NOTE_SILENT;
    end else begin
      for (int i = 0; i < NBANKS; i++)
        if (we && wr_idx == SLOT_W'(i)) tbl_q[i] <= wr_note;
        else if (clr && tbl_q[i] == clr_note) tbl_q[i] <= NOTE_SILENT;
    end
  end
  always_comb begin
    busy = '0;
    for (int i = 0; i < NBANKS; i++) busy[i] = tbl_q[i] != NOTE_SILENT;
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: note-on/off event FSM over a voice table plus round-robin slot stream
module voice_allocator import synth_pkg::*; #(
  parameter int NBANKS = synth_pkg::NBANKS,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_valid,
  input  logic              i_on,
  input  logic [6:0]        i_note,
  output logic              o_ready,
  output logic [6:0]        o_midi,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_valid,
  output logic [NBANKS-1:0] o_busy
);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NBANKS - 1);
  state_t state_q;
  logic on_q, match_q, free_q, ready_q, valid_q, we, clr;
  logic [6:0] note_q, midi_q, scan_note, stream_note;
  logic [SLOT_W-1:0] idx_q, match_idx_q, free_idx_q, steal_q, s_q, slot_q, wr_idx;
  logic [NBANKS-1:0] busy, busy_q;
  voice_table #(.NBANKS(NBANKS), .SLOT_W(SLOT_W)) u_table (
    .clk(clk), .rst(rst),
    .rd_a_idx(idx_q), .rd_a(scan_note),
    .rd_b_idx(s_q), .rd_b(stream_note),
    .we(we), .wr_idx(wr_idx), .wr_note(note_q),
    .clr(clr), .clr_note(note_q),
    .busy(busy)
  );
  // a matched note-on rewrites its own value, so a retrigger leaves the table unchanged
  always_comb begin
    we = state_q == COMMIT && on_q;
    clr = state_q == COMMIT && !on_q;
    wr_idx = match_q ? match_idx_q : free_q ? free_idx_q : steal_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      on_q <= 1'b0;
      note_q <= NOTE_SILENT;
      idx_q <= '0;
      match_q <= 1'b0;
      free_q <= 1'b0;
      match_idx_q <= '0;
      free_idx_q <= '0;
      steal_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid && i_note != NOTE_SILENT) begin
          on_q <= i_on;
          note_q <= i_note;
          match_q <= 1'b0;
          free_q <= 1'b0;
          idx_q <= '0;
          ready_q <= 1'b0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (scan_note == note_q && !match_q) begin
            match_q <= 1'b1;
            match_idx_q <= idx_q;
          end
          if (scan_note == NOTE_SILENT && !free_q) begin
            free_q <= 1'b1;
            free_idx_q <= idx_q;
          end
          idx_q <= idx_q == LAST ? '0 : idx_q + 1'b1;
          if (idx_q == LAST) state_q <= COMMIT;
        end
        COMMIT: begin
          if (on_q && !match_q && !free_q) steal_q <= steal_q == LAST ? '0 : steal_q + 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      slot_q <= '0;
      midi_q <= NOTE_SILENT;
      valid_q <= 1'b0;
      busy_q <= '0;
    end else begin
      busy_q <= busy;
      if (clk_en) begin
        midi_q <= stream_note;
        slot_q <= s_q;
        valid_q <= stream_note != NOTE_SILENT;
        s_q <= s_q == LAST ? '0 : s_q + 1'b1;
      end
    end
  end
  assign o_ready = ready_q;
  assign o_midi = midi_q;
  assign o_slot = slot_q;
  assign o_valid = valid_q;
  assign o_busy = busy_q;
endmodule
